// File: rtl/mmio_port_unit.sv
// Memory-mapped I/O port unit for the MEM stage: PortOut register, debounced
// PortIn register and a sticky change flag that is cleared by reading STATUS.
module mmio_port_unit #(
    parameter int               NBits           = 32,
    parameter int               IN_WIDTH        = 8,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter logic [NBits-1:0] PORT_OUT_ADDR   = 32'h1001_0024,
    parameter logic [NBits-1:0] PORT_IN_ADDR    = 32'h1001_0028,
    parameter logic [NBits-1:0] STATUS_ADDR     = 32'h1001_002C
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [NBits-1:0]    Address,
    input  logic [NBits-1:0]    WriteData,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [NBits-1:0]    ReadData,
    output logic                IOSelect,
    output logic [NBits-1:0]    PortOut,
    output logic                InChanged
);

    localparam int CountWidth = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CountWidth-1:0] CountLast = CountWidth'(DEBOUNCE_CYCLES - 1);

    logic                  selOut;
    logic                  selIn;
    logic                  selStatus;
    logic                  statusRead;

    logic [IN_WIDTH-1:0]   sync1;
    logic [IN_WIDTH-1:0]   sync2;
    logic [IN_WIDTH-1:0]   last;
    logic [IN_WIDTH-1:0]   stable;
    logic [IN_WIDTH-1:0]   stableNext;
    logic [CountWidth-1:0] count;
    logic [CountWidth-1:0] countNext;
    logic                  accept;
    logic                  changeFlag;
    logic                  changeFlagNext;

    // Full-width compare, so unaligned or aliased addresses never select the unit.
    assign selOut     = (Address == PORT_OUT_ADDR);
    assign selIn      = (Address == PORT_IN_ADDR);
    assign selStatus  = (Address == STATUS_ADDR);
    assign IOSelect   = selOut | selIn | selStatus;
    assign statusRead = MemRead & selStatus;
    assign InChanged  = changeFlag;

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            if (selOut) begin
                ReadData = PortOut;
            end else if (selIn) begin
                ReadData = NBits'(stable);
            end else if (selStatus) begin
                ReadData = NBits'(changeFlag);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PortOut <= '0;
        end else if (MemWrite && selOut) begin
            PortOut <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
        end else begin
            sync1 <= PortIn;
            sync2 <= sync1;
            last  <= sync2;
        end
    end

    // A sample that moved, or that matches what is already accepted, restarts the count.
    always_comb begin
        stableNext = stable;
        countNext  = count;
        accept     = 1'b0;
        if ((sync2 != last) || (sync2 == stable)) begin
            countNext = '0;
        end else if (count == CountLast) begin
            stableNext = sync2;
            countNext  = '0;
            accept     = 1'b1;
        end else begin
            countNext = count + CountWidth'(1);
        end
    end

    // Setting beats clearing so an acceptance coinciding with a STATUS read is not lost.
    always_comb begin
        changeFlagNext = changeFlag;
        if (accept) begin
            changeFlagNext = 1'b1;
        end else if (statusRead) begin
            changeFlagNext = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable     <= '0;
            count      <= '0;
            changeFlag <= 1'b0;
        end else begin
            stable     <= stableNext;
            count      <= countNext;
            changeFlag <= changeFlagNext;
        end
    end

endmodule

// File: tb/tb_mmio_port_unit.sv
// Scoreboard bench for mmio_port_unit: directed scenarios plus random traffic
// compared against a window-based behavioural model of the port.
module tb_mmio_port_unit;

    localparam int          NBits = 32;
    localparam int          InW   = 8;
    localparam int          Deb   = 4;
    localparam logic [31:0] OutA  = 32'h1001_0024;
    localparam logic [31:0] InA   = 32'h1001_0028;
    localparam logic [31:0] StA   = 32'h1001_002C;

    logic             clk;
    logic             reset;
    logic             MemWrite;
    logic             MemRead;
    logic [NBits-1:0] Address;
    logic [NBits-1:0] WriteData;
    logic [InW-1:0]   PortIn;
    logic [NBits-1:0] ReadData;
    logic             IOSelect;
    logic [NBits-1:0] PortOut;
    logic             InChanged;

    mmio_port_unit #(
        .NBits(NBits),
        .IN_WIDTH(InW),
        .DEBOUNCE_CYCLES(Deb),
        .PORT_OUT_ADDR(OutA),
        .PORT_IN_ADDR(InA),
        .STATUS_ADDR(StA)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .MemRead(MemRead),
        .Address(Address),
        .WriteData(WriteData),
        .PortIn(PortIn),
        .ReadData(ReadData),
        .IOSelect(IOSelect),
        .PortOut(PortOut),
        .InChanged(InChanged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        ios;
        logic [31:0] pout;
        logic        inch;
    } expect_t;

    expect_t     scoreQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastPreRd;
    logic        lastPreIos;

    // Model state: the input is accepted once the last Deb+1 synchronized samples agree.
    logic [31:0] mPortOut;
    logic        mFlag;
    logic [7:0]  mStable;
    logic [7:0]  mSync1;
    logic [7:0]  mSync2;
    logic [7:0]  win[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void modelReset();
        mPortOut = '0;
        mFlag    = 1'b0;
        mStable  = '0;
        mSync1   = '0;
        mSync2   = '0;
        win.delete();
    endfunction

    function automatic expect_t predict(input logic mr, input logic [31:0] addr);
        expect_t e;
        e.ios  = (addr == OutA) || (addr == InA) || (addr == StA);
        e.rd   = '0;
        if (mr && addr == OutA) e.rd = mPortOut;
        if (mr && addr == InA)  e.rd = {24'h0, mStable};
        if (mr && addr == StA)  e.rd = {31'h0, mFlag};
        e.pout = mPortOut;
        e.inch = mFlag;
        return e;
    endfunction

    function automatic void modelEdge(input logic mr, input logic mw, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [7:0] pin);
        logic [7:0] s;
        bit         accept;
        s = mSync2;
        win.push_back(s);
        if (win.size() > Deb + 1) win.delete(0);
        accept = (win.size() == Deb + 1) && (s != mStable);
        foreach (win[i]) if (win[i] != s) accept = 1'b0;
        if (accept) begin
            mStable = s;
            mFlag   = 1'b1;
        end else if (mr && addr == StA) begin
            mFlag = 1'b0;
        end
        if (mw && addr == OutA) mPortOut = wd;
        mSync2 = mSync1;
        mSync1 = pin;
    endfunction

    // Called just after a rising edge; drives one bus cycle and returns just after the next edge.
    task automatic applyStimulus(input logic mr, input logic mw, input logic [31:0] addr,
                                 input logic [31:0] wd, input logic [7:0] pin);
        MemRead   = mr;
        MemWrite  = mw;
        Address   = addr;
        WriteData = wd;
        PortIn    = pin;
        scoreQ.push_back(predict(mr, addr));
        #1;
        lastPreRd  = ReadData;
        lastPreIos = IOSelect;
        @(posedge clk);
        modelEdge(mr, mw, addr, wd, pin);
        #1;
    endtask

    task automatic resetTask();
        @(negedge clk);
        #2;
        reset    = 1'b1;
        MemRead  = 1'b1;
        MemWrite = 1'b0;
        Address  = OutA;
        modelReset();
        #1;
        checkOutput("rst_portout", PortOut, 32'h0);
        checkOutput("rst_inchanged", {31'h0, InChanged}, 32'h0);
        checkOutput("rst_readdata", ReadData, 32'h0);
        checkOutput("rst_iosel", {31'h0, IOSelect}, 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        expect_t e;
        forever begin
            @(negedge clk);
            if (!reset && scoreQ.size() != 0) begin
                e = scoreQ.pop_front();
                checkOutput("sb_readdata", ReadData, e.rd);
                checkOutput("sb_iosel", {31'h0, IOSelect}, {31'h0, e.ios});
                checkOutput("sb_portout", PortOut, e.pout);
                checkOutput("sb_inchanged", {31'h0, InChanged}, {31'h0, e.inch});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] run did not complete");
    end

    initial begin : stimulus
        logic [7:0]  pin;
        logic [31:0] addr;
        int          hold;
        reset     = 1'b1;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
        PortIn    = '0;
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("init_portout", PortOut, 32'h0);
        checkOutput("init_inchanged", {31'h0, InChanged}, 32'h0);
        checkOutput("init_iosel", {31'h0, IOSelect}, 32'h0);
        reset = 1'b0;

        applyStimulus(1'b0, 1'b1, OutA, 32'hDEAD_BEEF, 8'h00);
        checkOutput("store_portout", PortOut, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 1'b0, OutA, 32'h0, 8'h00);
        checkOutput("load_portout", lastPreRd, 32'hDEAD_BEEF);
        checkOutput("load_iosel", {31'h0, lastPreIos}, 32'h1);

        for (int i = 1; i <= 13; i++) begin
            applyStimulus(1'b1, 1'b0, InA, 32'h0, (i <= 3) ? 8'h3C : 8'h00);
            checkOutput("glitch_stable", ReadData, 32'h0);
            checkOutput("glitch_flag", {31'h0, InChanged}, 32'h0);
        end

        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'hA5);
            checkOutput("debounce_stable", ReadData, (i == 7) ? 32'hA5 : 32'h0);
            checkOutput("debounce_flag", {31'h0, InChanged}, (i == 7) ? 32'h1 : 32'h0);
        end
        applyStimulus(1'b1, 1'b0, StA, 32'h0, 8'hA5);
        checkOutput("status_read", lastPreRd, 32'h1);
        checkOutput("status_cleared", {31'h0, InChanged}, 32'h0);

        for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h11);
        checkOutput("race_pre_flag", {31'h0, InChanged}, 32'h1);
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h22);
        applyStimulus(1'b1, 1'b0, StA, 32'h0, 8'h22);
        checkOutput("race_read", lastPreRd, 32'h1);
        checkOutput("race_flag_kept", {31'h0, InChanged}, 32'h1);
        applyStimulus(1'b1, 1'b0, StA, 32'h0, 8'h22);
        checkOutput("race_read2", lastPreRd, 32'h1);
        checkOutput("race_flag_cleared", {31'h0, InChanged}, 32'h0);
        applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h22);
        checkOutput("race_stable", lastPreRd, 32'h22);

        applyStimulus(1'b1, 1'b0, 32'h1001_0025, 32'h0, 8'h22);
        checkOutput("dec_0025_rd", lastPreRd, 32'h0);
        checkOutput("dec_0025_sel", {31'h0, lastPreIos}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h1001_0030, 32'h0, 8'h22);
        checkOutput("dec_0030_rd", lastPreRd, 32'h0);
        checkOutput("dec_0030_sel", {31'h0, lastPreIos}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0024, 32'h0, 8'h22);
        checkOutput("dec_low_rd", lastPreRd, 32'h0);
        checkOutput("dec_low_sel", {31'h0, lastPreIos}, 32'h0);
        applyStimulus(1'b0, 1'b1, InA, 32'h1234_5678, 8'h22);
        applyStimulus(1'b0, 1'b1, StA, 32'hFFFF_FFFF, 8'h22);
        checkOutput("ro_portout", PortOut, 32'hDEAD_BEEF);
        checkOutput("ro_flag", {31'h0, InChanged}, 32'h0);
        applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h22);
        checkOutput("ro_stable", lastPreRd, 32'h22);

        applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h5A);
        applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h5A);
        resetTask();
        for (int i = 1; i <= 7; i++) begin
            applyStimulus(1'b1, 1'b0, InA, 32'h0, 8'h5A);
            checkOutput("rst_debounce", ReadData, (i == 7) ? 32'h5A : 32'h0);
        end

        pin  = 8'h5A;
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                pin  = ($urandom_range(3) == 0) ? (pin ^ 8'h01) : 8'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            case ($urandom_range(5))
                0:       addr = OutA;
                1:       addr = InA;
                2:       addr = StA;
                3:       addr = OutA + 32'h1;
                4:       addr = StA + 32'h4;
                default: addr = $urandom;
            endcase
            applyStimulus(1'($urandom_range(1)), ($urandom_range(3) == 0), addr, $urandom, pin);
            if (i == 200) resetTask();
        end

        for (int k = 0; k < 5 && scoreQ.size() != 0; k++) @(negedge clk);
        if (scoreQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", scoreQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
